muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit; supplies results for R-type opcode 0110011, funct7 0000001.
//  The combinational ALU emits 0 for these encodings, so this unit owns them.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_sign_unit.sv | 51 +++++
 rtl/muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the RV32M multiply/divide unit
//
// Purpose: opcode/funct7 match constants, the funct3 operation enum and the
// control FSM state enum used by muldiv_unit and muldiv_sign_unit.
// Ports: none (package).
package muldiv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_unit.sv
// rtl/muldiv_sign_unit.sv - operand magnitude/sign extraction and final negate
//
// Purpose: combinational helper. Converts the raw operands into magnitudes
// plus sign flags according to the operation's signedness, and applies the
// conditional two's-complement negate to the finished 2*XLEN value.
// Ports:
//   funct3   in   3        operation selecting operand signedness
//   src_a    in   XLEN     raw rs1 value
//   src_b    in   XLEN     raw rs2 value
//   abs_a    out  XLEN     |src_a| (src_a itself when treated unsigned)
//   abs_b    out  XLEN     |src_b|
//   sign_a   out  1        src_a is treated as negative
//   sign_b   out  1        src_b is treated as negative
//   fix_in   in   2*XLEN   unsigned result to sign-correct
//   fix_neg  in   1        negate fix_in
//   fix_out  out  2*XLEN   sign-corrected result
module muldiv_sign_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  output logic [XLEN-1:0]   abs_a,
  output logic [XLEN-1:0]   abs_b,
  output logic              sign_a,
  output logic              sign_b,
  input  logic [2*XLEN-1:0] fix_in,
  input  logic              fix_neg,
  output logic [2*XLEN-1:0] fix_out
);

  funct3_e op;
  logic    a_signed;
  logic    b_signed;

  always_comb begin
    op       = funct3_e'(funct3);
    a_signed = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    b_signed = (op == MULH) || (op == DIV) || (op == REM);
    sign_a   = a_signed && src_a[XLEN-1];
    sign_b   = b_signed && src_b[XLEN-1];
    // Negating the most negative value wraps back to itself, which read as
    // unsigned is exactly its magnitude.
    abs_a    = sign_a ? -src_a : src_a;
    abs_b    = sign_b ? -src_b : src_b;
    fix_out  = fix_neg ? -fix_in : fix_in;
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose: accepts OP-opcode/funct7=0000001 instructions, runs XLEN
// shift-add (multiply) or restoring-subtract (divide) steps on operand
// magnitudes, then sign-corrects and returns the result tagged with rd.
// Ports:
//   clk          in   1     rising-edge clock
//   n_rst        in   1     asynchronous active-low reset
//   in_valid     in   1     request qualifier
//   instruction  in   32    instruction word (opcode/funct3/funct7/rd used)
//   src_A        in   XLEN  rs1 value
//   src_B        in   XLEN  rs2 value
//   flush        in   1     abort in-flight op; blocks acceptance
//   ready        out  1     idle, can accept
//   busy         out  1     op in flight
//   done         out  1     one-cycle result-valid pulse
//   result       out  XLEN  last result, held until next completion
//   rd_out       out  5     rd of the last completed op
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] src_A,
  input  logic [XLEN-1:0] src_B,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              done_q, done_d;

  logic [XLEN-1:0]   abs_a, abs_b;
  logic              sign_a, sign_b;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;

  logic              accept;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic              unused_bits;

  assign unused_bits = ^{instruction[24:15], div_diff[XLEN]};

  muldiv_sign_unit #(.XLEN(XLEN)) u_sign (
    .funct3  (instruction[14:12]),
    .src_a   (src_A),
    .src_b   (src_B),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .sign_a  (sign_a),
    .sign_b  (sign_b),
    .fix_in  (fix_in),
    .fix_neg (fix_neg),
    .fix_out (fix_out)
  );

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole {carry, high, low} right by one.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: high half is the partial remainder, low half shifts dividend
    // bits out and quotient bits in. rem_sh keeps the bit shifted out of the
    // remainder so a remainder >= 2^(XLEN-1) is not truncated.
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = {1'b0, rem_sh} - {2'b0, opb_q};
    div_next = div_diff[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  always_comb begin
    fix_in  = acc_q;
    fix_neg = sign_a_q ^ sign_b_q;
    case (funct3_e'(funct3_q))
      DIV, DIVU: fix_in = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
      REM, REMU: begin
        fix_in  = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        fix_neg = sign_a_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;

    accept = in_valid && !flush && (state_q == IDLE)
          && (instruction[6:0] == OPC_OP) && (instruction[31:25] == F7_MULDIV);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CALC;
          cnt_d    = '0;
          funct3_d = instruction[14:12];
          rd_d     = instruction[11:7];
          opa_d    = abs_a;
          opb_d    = abs_b;
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          // Multiply iterates over the multiplier (B); divide over the dividend (A).
          acc_d    = instruction[14] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = funct3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        rd_out_d = rd_q;
        case (funct3_e'(funct3_q))
          MUL:               result_d = fix_out[XLEN-1:0];
          MULH, MULHSU,
          MULHU:             result_d = fix_out[2*XLEN-1:XLEN];
          // A zero divisor yields an all-ones quotient regardless of sign.
          DIV, DIVU:         result_d = (opb_q == '0) ? '1 : fix_out[XLEN-1:0];
          default:           result_d = fix_out[XLEN-1:0];
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      funct3_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == CALC);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] src_A = '0;
  logic [31:0] src_B = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .in_valid    (in_valid),
    .instruction (instruction),
    .src_A       (src_A),
    .src_B       (src_B),
    .flush       (flush),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .rd_out      (rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Presents one request for exactly the accepting edge, then drops in_valid.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    instruction = enc(7'b0000001, f3, rd);
    src_A = a;
    src_B = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (100 = timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100 && done !== 1'b1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    start_op(f3, a, b, rd);
    wait_done(lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 33", name, lat);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, exp);
    end
    checks++;
    if (rd_out !== rd) begin
      errors++;
      $display("FAIL %s rd_out: got %0d expected %0d", name, rd_out, rd);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready, busy, done, result, rd_out} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd0}) begin
      errors++;
      $display("FAIL reset_state: got r=%b b=%b d=%b res=%h rd=%0d expected r=1 b=0 d=0 res=0 rd=0",
               ready, busy, done, result, rd_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB);
  endtask

  task automatic test_mulh();
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_div();
    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
    run_op("divu_100_7", 3'b101, 32'd100,      32'd7, 5'd6, 32'd14);
    run_op("remu_100_7", 3'b111, 32'd100,      32'd7, 5'd7, 32'd2);
  endtask

  task automatic test_div_special();
    run_op("div_by_zero",  3'b100, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF);
    run_op("remu_by_zero", 3'b111, 32'd5,         32'd0,         5'd9,  32'd5);
    run_op("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    run_op("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
  endtask

  task automatic test_hold_valid();
    int lat;
    int busy_drops;
    busy_drops = 0;
    @(negedge clk);
    instruction = enc(7'b0000001, 3'b101, 5'd13);
    src_A = 32'd100;
    src_B = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (lat < 100 && done !== 1'b1) begin
      if (lat < 32 && busy !== 1'b1) busy_drops++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL hold_valid latency: got %0d expected 33", lat);
    end
    checks++;
    if (busy_drops !== 0) begin
      errors++;
      $display("FAIL hold_valid busy: got %0d idle cycles expected 0", busy_drops);
    end
    checks++;
    if (result !== 32'd14) begin
      errors++;
      $display("FAIL hold_valid result: got %h expected %h", result, 32'd14);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_valid second_accept: got busy=%b ready=%b expected busy=0 ready=1", busy, ready);
    end
  endtask

  task automatic test_flush();
    int pulses;
    run_op("flush_pre", 3'b101, 32'd100, 32'd7, 5'd9, 32'd14);
    start_op(3'b000, 32'd3, 32'd3, 5'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL flush_no_done: got %0d pulses expected 0", pulses);
    end
    checks++;
    if (result !== 32'd14 || rd_out !== 5'd9) begin
      errors++;
      $display("FAIL flush_hold: got res=%h rd=%0d expected res=%h rd=9", result, rd_out, 32'd14);
    end
    // Flush in the same cycle as a valid request blocks acceptance.
    @(negedge clk);
    instruction = enc(7'b0000001, 3'b000, 5'd4);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_vs_accept: got busy=%b ready=%b expected busy=0 ready=1", busy, ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    start_op(3'b001, 32'd5, 32'd6, 5'd17);
    repeat (19) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, result, rd_out} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd0}) begin
      errors++;
      $display("FAIL reset_mid_op: got r=%b b=%b d=%b res=%h rd=%0d expected r=1 b=0 d=0 res=0 rd=0",
               ready, busy, done, result, rd_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_non_muldiv();
    int bad;
    bad = 0;
    @(negedge clk);
    instruction = enc(7'b0000000, 3'b000, 5'd20);
    src_A = 32'd1;
    src_B = 32'd2;
    in_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL add_ignored: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_special();
    test_hold_valid();
    test_flush();
    test_reset_mid_op();
    test_non_muldiv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
